// File: rtl/byte_divider_seq.sv
// Sequential restoring divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module byte_divider_seq #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] dividend_sr_q, dividend_sr_d;
    logic [DIVIDEND_W-1:0] quotient_sr_q, quotient_sr_d;
    logic [DIVISOR_W:0]    partial_q, partial_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic                  take;
    logic [DIVISOR_W:0]    partial_step;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // One restoring step; the extra partial bit keeps the trial from overflowing.
    always_comb begin
        trial        = {partial_q[DIVISOR_W-1:0], dividend_sr_q[DIVIDEND_W-1]};
        diff         = trial - {1'b0, divisor_q};
        take         = (trial >= {1'b0, divisor_q});
        partial_step = take ? diff : trial;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (count_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_comb begin
        dividend_sr_d = dividend_sr_q;
        quotient_sr_d = quotient_sr_q;
        partial_d     = partial_q;
        divisor_d     = divisor_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        dbz_d         = dbz_q;
        if (accept) begin
            if (divisor == '0) begin
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
            end else begin
                dividend_sr_d = dividend;
                divisor_d     = divisor;
                quotient_sr_d = '0;
                partial_d     = '0;
                count_d       = '0;
                dbz_d         = 1'b0;
            end
        end else if (state_q == S_RUN) begin
            partial_d     = partial_step;
            dividend_sr_d = {dividend_sr_q[DIVIDEND_W-2:0], 1'b0};
            quotient_sr_d = {quotient_sr_q[DIVIDEND_W-2:0], take};
            count_d       = count_q + CNT_W'(1);
            // Final step publishes the result including the bit just computed.
            if (count_q == LAST_CNT) begin
                quotient_d  = {quotient_sr_q[DIVIDEND_W-2:0], take};
                remainder_d = partial_step[DIVISOR_W-1:0];
                count_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_sr_q <= '0;
            quotient_sr_q <= '0;
            partial_q     <= '0;
            divisor_q     <= '0;
            count_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            dbz_q         <= 1'b0;
        end else begin
            dividend_sr_q <= dividend_sr_d;
            quotient_sr_q <= quotient_sr_d;
            partial_q     <= partial_d;
            divisor_q     <= divisor_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            dbz_q         <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
